// File: rtl/riscv_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// riscv_issue_scoreboard
//
// In-order issue scoreboard for a simple RISC-V pipeline. It keeps one
// pending-write bit per architectural register. A decoded instruction is
// accepted only when:
//   - none of its source or destination registers has a write in flight,
//   - the in-flight table has room for another write, and
//   - the single-entry execute holding register is free.
// Serializing instructions (fence, system, CSR, privilege change, trap) wait
// in the DRAIN state until every pending write has retired.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   decoded-instruction handshake
//   in_rs1/rs2/rd       register indices
//   in_uses_rs1/rs2     source-operand usage flags
//   in_writes_rd        destination-write flag
//   in_category         instruction category
//   out_valid/out_ready execute-stage handshake
//   out_rd/out_category registered copies of the accepted instruction
//   wb_valid/wb_rd      writeback completion of one destination register
//   flush               drops the held instruction and all tracking state
//   busy_mask           pending-write bit per register (bit 0 always 0)
//   outstanding         number of set bits in busy_mask
//   wb_err              one-cycle pulse after a writeback to a non-busy register
// -----------------------------------------------------------------------------
module riscv_issue_scoreboard #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_uses_rs1,
    input  logic             in_uses_rs2,
    input  logic             in_writes_rd,
    input  logic [3:0]       in_category,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [3:0]       out_category,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] outstanding,
    output logic             wb_err
);

    // Instruction category encoding shared with the decoder
    localparam logic [3:0] CAT_SYNCH       = 4'd8;
    localparam logic [3:0] CAT_SYSTEM      = 4'd9;
    localparam logic [3:0] CAT_CSR         = 4'd10;
    localparam logic [3:0] CAT_CHANGELEVEL = 4'd11;
    localparam logic [3:0] CAT_TRAP        = 4'd12;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      wb_onehot;
    logic [31:0]      busy_eff;
    logic             wb_hit;
    logic [CNT_W-1:0] outstanding_eff;
    logic             tracked;
    logic             hazard;
    logic             full;
    logic             serializing;
    logic             out_free;
    logic             drain_done;
    logic             serialize_block;
    logic             accept;
    logic [31:0]      busy_next;
    logic [CNT_W-1:0] outstanding_next;

    // A writeback in this cycle already frees its register for hazard and
    // capacity purposes, so a dependent instruction can issue in the same cycle.
    assign wb_onehot       = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign busy_eff        = busy_mask & ~wb_onehot;
    assign wb_hit          = wb_valid && (wb_rd != 5'd0) && busy_mask[wb_rd];
    assign outstanding_eff = outstanding - CNT_W'(wb_hit);

    // busy_eff[0] is always 0, so register x0 never creates a hazard
    assign tracked = in_writes_rd && (in_rd != 5'd0);
    assign hazard  = (in_uses_rs1 && busy_eff[in_rs1])
                  || (in_uses_rs2 && busy_eff[in_rs2])
                  || (tracked && busy_eff[in_rd]);
    assign full    = tracked && (outstanding_eff == MAX_CNT);

    assign serializing = (in_category == CAT_SYNCH)
                      || (in_category == CAT_SYSTEM)
                      || (in_category == CAT_CSR)
                      || (in_category == CAT_CHANGELEVEL)
                      || (in_category == CAT_TRAP);

    assign out_free        = !out_valid || out_ready;
    assign drain_done      = (outstanding_eff == '0) && out_free;
    assign serialize_block = in_valid && serializing && !drain_done;
    assign accept          = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and in_ready. In DRAIN the held serializing instruction is
    // accepted in the same cycle the pipeline becomes empty.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        unique case (state)
            RUN: begin
                in_ready = !flush && !hazard && !full && !serialize_block && out_free;
                if (serialize_block) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = RUN;
                    in_ready   = !flush && !hazard && !full;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (flush) begin
            state_next = RUN;
        end
    end

    // Busy-bit update: a new issue to the register being written back in the
    // same cycle leaves the bit set and the counter unchanged (clear, then set).
    always_comb begin
        busy_next = busy_mask;
        if (wb_hit) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (accept && tracked) begin
            busy_next[in_rd] = 1'b1;
        end
        outstanding_next = outstanding + CNT_W'(accept && tracked) - CNT_W'(wb_hit);
    end

    // Tracking table, execute holding register and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_rd       <= 5'd0;
            out_category <= 4'd0;
            busy_mask    <= 32'd0;
            outstanding  <= '0;
            wb_err       <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            busy_mask   <= 32'd0;
            outstanding <= '0;
            wb_err      <= 1'b0;
        end else begin
            busy_mask   <= busy_next;
            outstanding <= outstanding_next;
            wb_err      <= wb_valid && (wb_rd != 5'd0) && !busy_mask[wb_rd];
            if (accept) begin
                out_valid    <= 1'b1;
                out_rd       <= in_rd;
                out_category <= in_category;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_riscv_issue_scoreboard
//
// Directed bench for riscv_issue_scoreboard. A register-level model tracks
// which registers have writes pending and which instruction is held for
// execute; a compare process checks every DUT output against it on each
// falling edge. Directed scenarios also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_riscv_issue_scoreboard;

    localparam int MAXO = 8;
    localparam int CW   = $clog2(MAXO + 1);

    localparam logic [3:0] CAT_ALU   = 4'd0;
    localparam logic [3:0] CAT_STORE = 4'd2;
    localparam logic [3:0] CAT_SYNCH = 4'd8;
    localparam logic [3:0] CAT_SYS   = 4'd9;
    localparam logic [3:0] CAT_CSR   = 4'd10;
    localparam logic [3:0] CAT_CHLVL = 4'd11;
    localparam logic [3:0] CAT_TRAP  = 4'd12;

    localparam logic [4:0] T0 = 5'd5,  T1 = 5'd6,  T2 = 5'd7,  S0 = 5'd8;
    localparam logic [4:0] S1 = 5'd9,  A0 = 5'd10, A1 = 5'd11, A2 = 5'd12;
    localparam logic [4:0] S2 = 5'd18, T6 = 5'd31;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [4:0]    in_rd;
    logic          in_uses_rs1;
    logic          in_uses_rs2;
    logic          in_writes_rd;
    logic [3:0]    in_category;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    out_rd;
    logic [3:0]    out_category;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic          flush;
    logic [31:0]   busy_mask;
    logic [CW-1:0] outstanding;
    logic          wb_err;

    int checks_total  = 0;
    int checks_passed = 0;

    riscv_issue_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_uses_rs1  (in_uses_rs1),
        .in_uses_rs2  (in_uses_rs2),
        .in_writes_rd (in_writes_rd),
        .in_category  (in_category),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd       (out_rd),
        .out_category (out_category),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy_mask    (busy_mask),
        .outstanding  (outstanding),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_busy [32];
    bit         m_ov;
    logic [4:0] m_rd;
    logic [3:0] m_cat;
    bit         m_err;
    bit         m_drain;
    bit         m_ok = 1'b0;

    function automatic bit is_serial(input logic [3:0] c);
        return (c == CAT_SYNCH) || (c == CAT_SYS) || (c == CAT_CSR)
            || (c == CAT_CHLVL) || (c == CAT_TRAP);
    endfunction

    // Register pending after accounting for a writeback arriving now
    function automatic bit eff_busy(input logic [4:0] r);
        return m_busy[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic int eff_count();
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (eff_busy(5'(i))) n++;
        end
        return n;
    endfunction

    function automatic int pend_count();
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_busy[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_tracked();
        return in_writes_rd && in_rd != 5'd0;
    endfunction

    function automatic bit m_hazard();
        return (in_uses_rs1 && eff_busy(in_rs1)) || (in_uses_rs2 && eff_busy(in_rs2))
            || (m_tracked() && eff_busy(in_rd));
    endfunction

    function automatic bit m_pipe_empty();
        return eff_count() == 0 && (!m_ov || out_ready);
    endfunction

    function automatic bit m_sblock();
        return in_valid && is_serial(in_category) && !m_pipe_empty();
    endfunction

    function automatic bit m_ready();
        bit full;
        full = m_tracked() && eff_count() == MAXO;
        if (flush) return 1'b0;
        if (m_drain) return m_pipe_empty() && !m_hazard() && !full;
        return (!m_ov || out_ready) && !m_hazard() && !full && !m_sblock();
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit sb;
        bit empty;
        bit trk;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_ov = 1'b0; m_rd = '0; m_cat = '0; m_err = 1'b0; m_drain = 1'b0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (flush) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_ov = 1'b0; m_err = 1'b0; m_drain = 1'b0;
            end else begin
                acc   = in_valid && m_ready();
                sb    = m_sblock();
                empty = m_pipe_empty();
                trk   = m_tracked();
                m_err = wb_valid && wb_rd != 5'd0 && !m_busy[wb_rd];
                if (wb_valid && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
                if (acc && trk) m_busy[in_rd] = 1'b1;
                if (acc) begin
                    m_ov = 1'b1; m_rd = in_rd; m_cat = in_category;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
                if (!m_drain && sb) m_drain = 1'b1;
                else if (m_drain && empty) m_drain = 1'b0;
            end
        end
    end

    // Compare process: every cycle outside reset
    always @(negedge clk) begin
        if (m_ok && !rst) begin
            check("model_in_ready", 32'(in_ready), 32'(m_ready()));
            check("model_out_valid", 32'(out_valid), 32'(m_ov));
            check("model_busy_mask", busy_mask, pend_vec());
            check("model_outstanding", 32'(outstanding), 32'(pend_count()));
            check("model_wb_err", 32'(wb_err), 32'(m_err));
            if (m_ov) begin
                check("model_out_rd", 32'(out_rd), 32'(m_rd));
                check("model_out_category", 32'(out_category), 32'(m_cat));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic wr, input logic [3:0] cat, input logic ordy,
                                 input logic wbv, input logic [4:0] wbr, input logic fl);
        in_valid = v;  in_rs1 = rs1; in_uses_rs1 = u1; in_rs2 = rs2; in_uses_rs2 = u2;
        in_rd = rd;    in_writes_rd = wr; in_category = cat; out_ready = ordy;
        wb_valid = wbv; wb_rd = wbr; flush = fl;
    endtask

    // Literal expectations, sampled mid-cycle after inputs have settled
    task automatic checkOutput(input string name, input logic rdy, input logic ov,
                               input logic [31:0] busy, input int cnt, input logic err);
        #2;
        check({name, "_in_ready"}, 32'(in_ready), 32'(rdy));
        check({name, "_out_valid"}, 32'(out_valid), 32'(ov));
        check({name, "_busy_mask"}, busy_mask, busy);
        check({name, "_outstanding"}, 32'(outstanding), 32'(cnt));
        check({name, "_wb_err"}, 32'(wb_err), 32'(err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, CAT_ALU, ordy, 0, 0, 0);
    endtask

    task automatic issueWrite(input logic [4:0] rd, input logic ordy);
        applyStimulus(1, 0, 0, 0, 0, rd, 1, CAT_ALU, ordy, 0, 0, 0);
    endtask

    task automatic writeBack(input logic [4:0] r);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, CAT_ALU, 1, 1, r, 0);
    endtask

    logic [4:0] full_regs [8];

    initial begin
        full_regs = '{T0, T1, T2, S0, S1, A0, A1, A2};
        rst = 1'b1;
        idle(0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        checkOutput("reset", 1, 0, 32'h0, 0, 0);
        check("reset_out_rd", 32'(out_rd), 32'd0);
        check("reset_out_category", 32'(out_category), 32'd0);
        step();

        // RAW: ADDI a0, then ADD reading a0 waits for its writeback
        applyStimulus(1, 0, 1, 0, 0, A0, 1, CAT_ALU, 1, 0, 0, 0);
        checkOutput("raw_addi", 1, 0, 32'h0, 0, 0);
        step();
        applyStimulus(1, A0, 1, 0, 0, A1, 1, CAT_ALU, 1, 0, 0, 0);
        checkOutput("raw_stall", 0, 1, 32'h400, 1, 0);
        step();
        applyStimulus(1, A0, 1, 0, 0, A1, 1, CAT_ALU, 1, 1, A0, 0);
        checkOutput("raw_bypass", 1, 0, 32'h400, 1, 0);
        step();
        writeBack(A1);
        checkOutput("raw_issued", 1, 1, 32'h800, 1, 0);
        step();
        idle(1);
        checkOutput("raw_clean", 1, 0, 32'h0, 0, 0);
        step();

        // Full: eight writes fill the table
        for (int i = 0; i < 8; i++) begin
            issueWrite(full_regs[i], 1);
            step();
        end
        issueWrite(5'd13, 1);
        checkOutput("full_block", 0, 1, 32'h1FE0, 8, 0);
        step();
        applyStimulus(1, 5'd2, 1, 5'd3, 1, 0, 0, CAT_STORE, 1, 0, 0, 0);
        checkOutput("full_store", 1, 0, 32'h1FE0, 8, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 5'd13, 1, CAT_ALU, 1, 1, T0, 0);
        checkOutput("full_wb_bypass", 1, 1, 32'h1FE0, 8, 0);
        step();
        idle(1);
        checkOutput("full_after", 1, 1, 32'h3FC0, 8, 0);
        step();
        for (int r = 6; r <= 13; r++) begin
            writeBack(5'(r));
            step();
        end

        // Serialize: CSR waits for two pending writes
        issueWrite(T0, 1);
        step();
        issueWrite(T1, 1);
        step();
        applyStimulus(1, S0, 1, 0, 0, T2, 1, CAT_CSR, 1, 0, 0, 0);
        checkOutput("ser_enter", 0, 1, 32'h60, 2, 0);
        step();
        applyStimulus(1, S0, 1, 0, 0, T2, 1, CAT_CSR, 1, 1, T0, 0);
        checkOutput("ser_drain", 0, 0, 32'h60, 2, 0);
        step();
        applyStimulus(1, S0, 1, 0, 0, T2, 1, CAT_CSR, 1, 1, T1, 0);
        checkOutput("ser_accept", 1, 0, 32'h40, 1, 0);
        step();
        issueWrite(S1, 1);
        checkOutput("ser_run", 1, 1, 32'h80, 1, 0);
        step();
        writeBack(T2);
        step();
        writeBack(S1);
        step();

        // Same-cycle writeback and reissue of s2, then spurious writeback
        issueWrite(S2, 1);
        step();
        applyStimulus(1, 0, 0, 0, 0, S2, 1, CAT_ALU, 1, 1, S2, 0);
        checkOutput("same_rd", 1, 1, 32'h40000, 1, 0);
        step();
        writeBack(T6);
        checkOutput("same_rd_after", 1, 1, 32'h40000, 1, 0);
        step();
        idle(1);
        checkOutput("spur_err", 1, 0, 32'h40000, 1, 1);
        step();
        idle(1);
        checkOutput("spur_pulse", 1, 0, 32'h40000, 1, 0);
        step();
        writeBack(S2);
        step();

        // Flush with a held instruction and three pending writes
        issueWrite(T0, 1);
        step();
        issueWrite(T1, 1);
        step();
        issueWrite(T2, 1);
        step();
        idle(0);
        checkOutput("flush_pre", 0, 1, 32'hE0, 3, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, S1, 1, CAT_ALU, 0, 1, 5'd20, 1);
        checkOutput("flush_cycle", 0, 1, 32'hE0, 3, 0);
        step();
        idle(0);
        checkOutput("flush_after", 1, 0, 32'h0, 0, 0);
        step();

        // Reset while draining discards everything
        issueWrite(T0, 1);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, CAT_CSR, 0, 0, 0, 0);
        checkOutput("rst_enter", 0, 1, 32'h20, 1, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(0);
        checkOutput("rst_drain", 1, 0, 32'h0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, CAT_CSR, 0, 0, 0, 0);
        checkOutput("rst_run", 1, 0, 32'h0, 0, 0);
        step();
        idle(1);
        repeat (3) step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/riscv_issue_scoreboard.md
RISCV_ISSUE_SCOREBOARD -- requirements
Module: riscv_issue_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8: maximum tracked in-flight register writes (range 1..31).
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_OUTSTANDING+1): outstanding-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  decoded instruction present.
REQ-006 in_ready  output  1  instruction accepted when in_valid && in_ready.
REQ-007 in_rs1, in_rs2, in_rd  input  5 each  riscv_reg_t register indices.
REQ-008 in_uses_rs1, in_uses_rs2, in_writes_rd  input  1 each  operand/destination usage flags.
REQ-009 in_category  input  4  riscv_instr_cateogry_t of the instruction.
REQ-010 out_valid  output  1  issued instruction held for the execute stage.
REQ-011 out_ready  input  1  execute stage takes the instruction when out_valid && out_ready.
REQ-012 out_rd  output  5;  out_category  output  4  registered copies of accepted fields.
REQ-013 wb_valid  input  1;  wb_rd  input  5  writeback completion of one destination register.
REQ-014 flush  input  1  discard held instruction and all tracking state.
REQ-015 busy_mask  output  32  pending-write bit per register; bit 0 always 0.
REQ-016 outstanding  output  CNT_W  count of set busy bits.
REQ-017 wb_err  output  1  one-cycle pulse: writeback to non-busy register.

Function
REQ-018 Tracked write: in_writes_rd && in_rd != ZERO; other instructions never set busy bits or change the counter.
REQ-019 Effective busy: busy_eff = busy_mask & ~(wb_valid ? onehot(wb_rd) : 0); same-cycle writeback bypass.
REQ-020 Hazard: (in_uses_rs1 && busy_eff[in_rs1]) || (in_uses_rs2 && busy_eff[in_rs2]) || (tracked write && busy_eff[in_rd]); rs/rd ZERO never hazard.
REQ-021 Full: tracked write && outstanding_eff == MAX_OUTSTANDING, where outstanding_eff excludes a same-cycle valid writeback.
REQ-022 Serializing categories: SYNCH, SYSTEM, CSR, CHANGELEVEL, TRAP.
REQ-023 FSM states RUN, DRAIN; reset state RUN.
REQ-024 RUN -> DRAIN: in_valid && serializing && (outstanding_eff != 0 || (out_valid && !out_ready)); in_ready = 0 that cycle.
REQ-025 DRAIN -> RUN: outstanding_eff == 0 && (!out_valid || out_ready); the serializing instruction is accepted in that same cycle if all other RUN conditions hold.
REQ-026 DRAIN holds in_ready = 0 until exit; input SHALL remain stable (upstream contract, asserted by bench).
REQ-027 in_ready (RUN) = !flush && !hazard && !full && !serialize_block && (!out_valid || out_ready).
REQ-028 Acceptance loads out_* next cycle (latency 1), sets out_valid, sets busy[in_rd] and increments counter for tracked writes.
REQ-029 out_valid clears on out_ready handshake with no new acceptance; back-to-back acceptance each cycle SHALL be supported.
REQ-030 Writeback with busy[wb_rd] set clears the bit and decrements counter; wb_rd == ZERO ignored silently.
REQ-031 Writeback with busy[wb_rd] clear: no state change, wb_err = 1 next cycle.
REQ-032 Simultaneous writeback and acceptance to same rd: bit remains set, counter unchanged (set wins).
REQ-033 Counter SHALL equal popcount(busy_mask) at every cycle; never wraps.
REQ-034 flush: next cycle out_valid = 0, busy_mask = 0, outstanding = 0, state RUN; in_ready = 0 during flush cycle; flush outranks acceptance and writeback (wb_err not raised).

Reset
REQ-035 rst SHALL take priority over flush and all inputs.
REQ-036 After reset: in_ready follows REQ-027 from the next cycle; out_valid 0, out_rd 0, out_category 0, busy_mask 0, outstanding 0, wb_err 0, state RUN.
REQ-037 Reset mid-DRAIN or with out_valid high SHALL discard the held instruction without handshake.

Verification
REQ-038 RAW: issue ADDI rd=A0 (10); next ADD rs1=A0 -> in_ready 0 until wb_rd=10; accepted in the wb cycle via bypass; busy_mask bit 10 re-set only if rd=A0.
REQ-039 Full: MAX_OUTSTANDING=8, issue 8 writes to T0..T2,S0,S1,A0..A2 with out_ready=1 -> outstanding=8, 9th write blocked, non-writing SW accepted; one wb -> 9th accepted same cycle.
REQ-040 Serialize: 2 outstanding, present CSRRW category CSR -> DRAIN, in_ready 0; second wb -> accepted that cycle, state RUN.
REQ-041 Same-cycle wb/issue rd=S2 (18) with bit set -> bit 18 stays 1, outstanding unchanged.
REQ-042 Spurious wb_rd=T6 with bit clear -> wb_err pulse 1 cycle, busy_mask and outstanding unchanged.
REQ-043 flush with out_valid=1, out_ready=0, 3 outstanding -> next cycle out_valid 0, busy_mask 0, outstanding 0, state RUN.
